mips32_mem_arbiter: RTL and testbench
=====================================

# mips32_mem_arbiter

Single-port memory arbiter and sequencer for the MIPS32 core. It shares one unified instruction/data memory between the instruction-fetch requester and the data-memory requester (load/store). Each access is sequenced through a fixed-latency memory port, one transaction at a time. Data requests have priority, and a starvation guard bounds how long fetch can be locked out.

## Interface
Parameters:
- AW, 9: memory word-address width (512 words)
- DW, 32: data width
- MEM_LAT, 2: cycles from a mem_en cycle to valid mem_rdata; legal range 1..8
- MAX_WAIT, 4: consecutive data grants tolerated while if_req is pending; legal range 1..15

Ports:
- clk_1 in 1: single clock; all logic on rising edge
- rst in 1: synchronous, active-high reset
- if_req in 1: fetch request; held with if_addr stable until if_gnt, may be withdrawn earlier
- if_addr in AW: fetch word address
- if_gnt out 1: combinational; fetch request accepted this cycle
- if_rvalid out 1: one-cycle pulse; if_rdata valid
- if_rdata out DW: fetched instruction word
- d_req in 1: data request; same hold rules as if_req
- d_we in 1: 1 = store, 0 = load
- d_addr in AW: data word address
- d_wdata in DW: store data
- d_gnt out 1: combinational; data request accepted this cycle
- d_rvalid out 1: one-cycle completion pulse for loads and stores
- d_rdata out DW: load data; 0 on store completion
- mem_en out 1: memory access strobe, registered
- mem_we out 1: memory write enable, registered; only high together with mem_en
- mem_addr out AW: registered memory address
- mem_wdata out DW: registered memory write data
- mem_rdata in DW: memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy out 1: high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate. With no request, stay in IDLE. When a request is granted, capture the owner, address, we and wdata, then go to ISSUE. Grants are only issued in IDLE, and at most one per cycle.
- ISSUE: mem_en=1 with captured mem_we, mem_addr and mem_wdata for exactly one cycle. Then go to WAIT and load the wait counter with MEM_LAT-1.
- WAIT: decrement the counter each cycle. When it reaches 0, mem_rdata is valid in that cycle. Register it into the owner's rdata (0 for stores), then go to DONE.
- DONE: the owner's rvalid is 1 for one cycle; the other rvalid stays 0. Go to IDLE.
- Arbitration in IDLE:
  - d_req only: grant data.
  - if_req only: grant fetch.
  - Both: grant data, unless starve_cnt == MAX_WAIT, in which case grant fetch.
- starve_cnt (4 bits):
  - +1 on each data grant made while if_req=1.
  - Cleared on any fetch grant.
  - Cleared in any IDLE cycle with if_req=0.
  - Saturates at MAX_WAIT.
- if_rdata and d_rdata hold their last value between pulses. Only rvalid qualifies them.
- Addresses are used unmodified; no bounds check. All AW-bit values are legal, and there is no wrap logic.

## Timing
- Reset (rst=1 at an edge):
  - State goes to IDLE; starve_cnt and wait counter to 0.
  - All outputs 0 the following cycle: gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
- Grant at cycle T has this sequence:
  - mem_en=1 at T+1.
  - mem_rdata sampled at T+1+MEM_LAT.
  - rvalid=1 at T+2+MEM_LAT.
  - Next grant possible at T+3+MEM_LAT.
  - Throughput: one access per MEM_LAT+3 cycles.
- gnt depends only on the current state, requests and starve_cnt. There is no combinational path from mem_rdata.
- Requests asserted while busy are not granted. They are arbitrated in the first IDLE cycle.
- Reset asserted in ISSUE, WAIT or DONE abandons the transaction:
  - No rvalid is produced.
  - An in-flight mem_en is not repeated.
  - mem_rdata returning later is ignored.
- A request withdrawn before its grant is never serviced.

## Test plan
MEM_LAT=2, MAX_WAIT=4 unless stated.
- Reset: hold rst 2 cycles with d_req=if_req=1 -> all outputs 0, no gnt. Release at cycle 0 -> d_gnt=1 at cycle 0, mem_en=1 at cycle 1.
- Fetch read: if_req=1, if_addr=0x005, mem returns 0x8C220004 at +2 -> if_gnt at T, mem_en/mem_addr=0x005/mem_we=0 at T+1, if_rvalid=1 and if_rdata=0x8C220004 at T+4, busy low at T+5.
- Store then load: d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF at T+1, d_rvalid=1 and d_rdata=0 at T+4. Then a load of 0x010 returning 0xDEADBEEF -> d_rdata=0xDEADBEEF with d_rvalid.
- Priority and starvation: d_req and if_req held continuously -> grants are D,D,D,D,F,D,D,D,D,F. Each if_rvalid carries fetch data and never data-port data.
- Back-to-back and withdraw: if_req pulsed 2 cycles during a data WAIT, then dropped -> no if_gnt, no if_rvalid. d_req held -> consecutive grants exactly 5 cycles apart. Repeat with MEM_LAT=1 (4 cycles) and MEM_LAT=8 (11 cycles).
- Reset mid-operation: rst for one cycle during WAIT -> no rvalid, mem_en stays 0, starve_cnt=0. A new request afterwards completes normally.

Source files
------------

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: fetch, data and memory-port signals shared by the arbiter and its neighbours
interface mips32_mem_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: single-port memory sequencer shared by fetch and data with a fetch starvation guard
module mips32_mem_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input logic clk_1,
    input logic rst,
    mips32_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [3:0]    wait_q, wait_d;
    logic [3:0]    starve_q, starve_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          idle, starved, d_gnt, if_gnt;

    assign idle    = state_q == IDLE && !rst;
    assign starved = starve_q == 4'(MAX_WAIT);
    assign d_gnt   = idle && bus.d_req && !(bus.if_req && starved);
    assign if_gnt  = idle && bus.if_req && !d_gnt;

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = state_q == DONE && !owner_q && !rst;
    assign bus.d_rvalid  = state_q == DONE && owner_q && !rst;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = state_q != IDLE;

    // Arbitrate in IDLE, issue one memory strobe, count out the latency, then pulse the owner's rvalid
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                starve_d = (if_gnt || !bus.if_req) ? 4'd0 :
                           (d_gnt && !starved) ? starve_q + 4'd1 : starve_q;
                if (d_gnt || if_gnt) begin
                    state_d     = ISSUE;
                    owner_d     = d_gnt;
                    we_d        = d_gnt && bus.d_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_gnt && bus.d_we;
                    mem_addr_d  = d_gnt ? bus.d_addr : bus.if_addr;
                    mem_wdata_d = d_gnt ? bus.d_wdata : '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wait_d  = 4'(MEM_LAT - 1);
            end
            WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = DONE;
                    if (owner_q) d_rdata_d = we_q ? '0 : bus.mem_rdata;
                    else if_rdata_d = bus.mem_rdata;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            wait_q      <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed checks of arbitration, sequencing, starvation guard and reset abort
module tb_mips32_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic clk_1 = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_1 = ~clk_1;

    mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) b2 ();
    mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
    mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) b8 ();

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .MAX_WAIT(4)) dut  (.clk_1(clk_1), .rst(rst), .bus(b2));
    mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_WAIT(4)) dut1 (.clk_1(clk_1), .rst(rst), .bus(b1));
    mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(8), .MAX_WAIT(4)) dut8 (.clk_1(clk_1), .rst(rst), .bus(b8));

    assign b1.mem_rdata = '0;
    assign b8.mem_rdata = '0;

    // Memory model for the MEM_LAT=2 instance: read data appears two cycles after the mem_en cycle
    logic [DW-1:0] mem [512];
    logic [511:0]  wr = '0;
    logic [DW-1:0] rd0, rd1;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return (a == 9'h005) ? 32'h8C220004 : (32'hA5000000 | 32'(a));
    endfunction

    always @(posedge clk_1) begin
        if (b2.mem_en && b2.mem_we) begin
            mem[b2.mem_addr] <= b2.mem_wdata;
            wr[b2.mem_addr]  <= 1'b1;
        end
        rd0 <= wr[b2.mem_addr] ? mem[b2.mem_addr] : dflt(b2.mem_addr);
        rd1 <= rd0;
    end
    assign b2.mem_rdata = rd1;

    task automatic nxt;
        @(negedge clk_1);
    endtask

    task automatic test_reset;
        b2.d_req = 1'b1; b2.if_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 9'h040; b2.if_addr = 9'h030;
        for (int i = 0; i < 2; i++) begin
            nxt; #1;
            n_cmp++;
            if ({b2.if_gnt, b2.d_gnt, b2.if_rvalid, b2.d_rvalid, b2.mem_en, b2.mem_we, b2.busy,
                 b2.mem_addr, b2.mem_wdata, b2.if_rdata, b2.d_rdata} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h want 0", {b2.if_gnt, b2.d_gnt, b2.if_rvalid, b2.d_rvalid,
                         b2.mem_en, b2.mem_we, b2.busy, b2.mem_addr, b2.mem_wdata, b2.if_rdata, b2.d_rdata});
            end
        end
        nxt; rst = 1'b0; #1;
        n_cmp++;
        if ({b2.d_gnt, b2.if_gnt} !== 2'b10) begin
            n_bad++; $display("FAIL reset_release_gnt: got %b want 10", {b2.d_gnt, b2.if_gnt});
        end
        nxt; b2.d_req = 1'b0; b2.if_req = 1'b0; #1;
        n_cmp++;
        if ({b2.mem_en, b2.mem_addr} !== {1'b1, 9'h040}) begin
            n_bad++; $display("FAIL reset_release_mem: got %h want %h", {b2.mem_en, b2.mem_addr}, {1'b1, 9'h040});
        end
        repeat (3) nxt;
        #1;
        n_cmp++;
        if ({b2.d_rvalid, b2.d_rdata} !== {1'b1, 32'hA5000040}) begin
            n_bad++; $display("FAIL reset_first_load: got %h want %h", {b2.d_rvalid, b2.d_rdata}, {1'b1, 32'hA5000040});
        end
    endtask

    task automatic test_fetch;
        nxt; b2.if_req = 1'b1; b2.if_addr = 9'h005; #1;
        n_cmp++;
        if ({b2.if_gnt, b2.d_gnt} !== 2'b10) begin
            n_bad++; $display("FAIL fetch_gnt: got %b want 10", {b2.if_gnt, b2.d_gnt});
        end
        nxt; b2.if_req = 1'b0; #1;
        n_cmp++;
        if ({b2.mem_en, b2.mem_we, b2.mem_addr, b2.busy} !== {1'b1, 1'b0, 9'h005, 1'b1}) begin
            n_bad++; $display("FAIL fetch_issue: got %h want %h", {b2.mem_en, b2.mem_we, b2.mem_addr, b2.busy},
                              {1'b1, 1'b0, 9'h005, 1'b1});
        end
        nxt; nxt; #1;
        n_cmp++;
        if ({b2.if_rvalid, b2.mem_en} !== 2'b00) begin
            n_bad++; $display("FAIL fetch_early: got %b want 00", {b2.if_rvalid, b2.mem_en});
        end
        nxt; #1;
        n_cmp++;
        if ({b2.if_rvalid, b2.d_rvalid, b2.if_rdata} !== {2'b10, 32'h8C220004}) begin
            n_bad++; $display("FAIL fetch_data: got %h want %h", {b2.if_rvalid, b2.d_rvalid, b2.if_rdata},
                              {2'b10, 32'h8C220004});
        end
        nxt; #1;
        n_cmp++;
        if ({b2.busy, b2.if_rvalid, b2.if_rdata} !== {2'b00, 32'h8C220004}) begin
            n_bad++; $display("FAIL fetch_after: got %h want %h", {b2.busy, b2.if_rvalid, b2.if_rdata},
                              {2'b00, 32'h8C220004});
        end
    endtask

    task automatic test_store_load;
        nxt; b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 9'h010; b2.d_wdata = 32'hDEADBEEF; #1;
        n_cmp++;
        if (b2.d_gnt !== 1'b1) begin
            n_bad++; $display("FAIL store_gnt: got %b want 1", b2.d_gnt);
        end
        nxt; b2.d_req = 1'b0; #1;
        n_cmp++;
        if ({b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata} !== {2'b11, 9'h010, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL store_issue: got %h want %h", {b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata},
                              {2'b11, 9'h010, 32'hDEADBEEF});
        end
        repeat (3) nxt;
        #1;
        n_cmp++;
        if ({b2.d_rvalid, b2.if_rvalid, b2.d_rdata} !== {2'b10, 32'h0}) begin
            n_bad++; $display("FAIL store_done: got %h want %h", {b2.d_rvalid, b2.if_rvalid, b2.d_rdata}, {2'b10, 32'h0});
        end
        nxt; b2.d_req = 1'b1; b2.d_we = 1'b0; #1;
        n_cmp++;
        if (b2.d_gnt !== 1'b1) begin
            n_bad++; $display("FAIL load_gnt: got %b want 1", b2.d_gnt);
        end
        nxt; b2.d_req = 1'b0; #1;
        n_cmp++;
        if ({b2.mem_en, b2.mem_we} !== 2'b10) begin
            n_bad++; $display("FAIL load_issue: got %b want 10", {b2.mem_en, b2.mem_we});
        end
        repeat (3) nxt;
        #1;
        n_cmp++;
        if ({b2.d_rvalid, b2.d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL load_data: got %h want %h", {b2.d_rvalid, b2.d_rdata}, {1'b1, 32'hDEADBEEF});
        end
    endtask

    task automatic test_priority;
        logic [9:0] got;
        int ng, ni, nd;
        got = '0; ng = 0; ni = 0; nd = 0;
        nxt; b2.d_req = 1'b1; b2.if_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 9'h020; b2.if_addr = 9'h030;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (b2.d_gnt || b2.if_gnt) begin
                if (ng < 10) got[9 - ng] = b2.if_gnt;
                ng++;
            end
            if (b2.if_rvalid) begin
                ni++; n_cmp++;
                if (b2.if_rdata !== 32'hA5000030) begin
                    n_bad++; $display("FAIL prio_if_rdata: got %h want %h", b2.if_rdata, 32'hA5000030);
                end
            end
            if (b2.d_rvalid) begin
                nd++; n_cmp++;
                if (b2.d_rdata !== 32'hA5000020) begin
                    n_bad++; $display("FAIL prio_d_rdata: got %h want %h", b2.d_rdata, 32'hA5000020);
                end
            end
            nxt;
            if (ng >= 10) begin
                b2.d_req = 1'b0; b2.if_req = 1'b0;
            end
        end
        n_cmp++;
        if (got !== 10'b0000100001) begin
            n_bad++; $display("FAIL prio_sequence: got %b want 0000100001 (1=fetch)", got);
        end
        n_cmp++;
        if ({ng, ni, nd} !== {32'd10, 32'd2, 32'd8}) begin
            n_bad++; $display("FAIL prio_counts: got grants=%0d if=%0d d=%0d want 10 2 8", ng, ni, nd);
        end
    endtask

    task automatic test_back_to_back;
        int g2[3], g1[3], g8[3];
        int k2, k1, k8;
        k2 = 0; k1 = 0; k8 = 0;
        for (int i = 0; i < 3; i++) begin g2[i] = 0; g1[i] = 0; g8[i] = 0; end
        b2.d_addr = 9'h020; b2.d_we = 1'b0; b2.d_req = 1'b1; b1.d_req = 1'b1; b8.d_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (b2.d_gnt && k2 < 3) begin g2[k2] = c; k2++; end
            if (b1.d_gnt && k1 < 3) begin g1[k1] = c; k1++; end
            if (b8.d_gnt && k8 < 3) begin g8[k8] = c; k8++; end
            n_cmp++;
            if (b2.if_gnt || b2.if_rvalid) begin
                n_bad++; $display("FAIL withdraw_serviced: cycle %0d if_gnt=%b if_rvalid=%b want 0 0", c, b2.if_gnt, b2.if_rvalid);
            end
            nxt;
            b2.if_req = (c + 1 == 2) || (c + 1 == 3);
        end
        b2.d_req = 1'b0; b1.d_req = 1'b0; b8.d_req = 1'b0;
        n_cmp++;
        if ({g2[0], g2[1] - g2[0], g2[2] - g2[1]} !== {32'd0, 32'd5, 32'd5}) begin
            n_bad++; $display("FAIL b2b_lat2: got first=%0d gaps %0d %0d want 0 5 5", g2[0], g2[1] - g2[0], g2[2] - g2[1]);
        end
        n_cmp++;
        if ({g1[1] - g1[0], g1[2] - g1[1]} !== {32'd4, 32'd4}) begin
            n_bad++; $display("FAIL b2b_lat1: got gaps %0d %0d want 4 4", g1[1] - g1[0], g1[2] - g1[1]);
        end
        n_cmp++;
        if ({g8[1] - g8[0], g8[2] - g8[1]} !== {32'd11, 32'd11}) begin
            n_bad++; $display("FAIL b2b_lat8: got gaps %0d %0d want 11 11", g8[1] - g8[0], g8[2] - g8[1]);
        end
        repeat (12) nxt;
    endtask

    task automatic test_reset_mid;
        int nd;
        nd = 0;
        nxt; b2.d_req = 1'b1; b2.if_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 9'h020; b2.if_addr = 9'h030;
        for (int c = 0; c < 17; c++) begin
            #1;
            if (b2.d_gnt) nd++;
            if (b2.if_gnt) nd += 100;
            nxt;
        end
        n_cmp++;
        if (nd !== 4) begin
            n_bad++; $display("FAIL rstmid_pre_grants: got code %0d want 4", nd);
        end
        rst = 1'b1;
        nxt; rst = 1'b0; #1;
        n_cmp++;
        if ({b2.d_gnt, b2.if_gnt, b2.mem_en, b2.d_rvalid, b2.if_rvalid} !== 5'b10000) begin
            n_bad++; $display("FAIL rstmid_after: got %b want 10000 (d_gnt,if_gnt,mem_en,d_rvalid,if_rvalid)",
                              {b2.d_gnt, b2.if_gnt, b2.mem_en, b2.d_rvalid, b2.if_rvalid});
        end
        nxt; b2.d_req = 1'b0; b2.if_req = 1'b0; #1;
        n_cmp++;
        if ({b2.d_rvalid, b2.if_rvalid, b2.mem_en, b2.mem_addr} !== {3'b001, 9'h020}) begin
            n_bad++; $display("FAIL rstmid_no_rvalid: got %h want %h", {b2.d_rvalid, b2.if_rvalid, b2.mem_en, b2.mem_addr},
                              {3'b001, 9'h020});
        end
        repeat (3) nxt;
        #1;
        n_cmp++;
        if ({b2.d_rvalid, b2.if_rvalid, b2.d_rdata} !== {2'b10, 32'hA5000020}) begin
            n_bad++; $display("FAIL rstmid_new_req: got %h want %h", {b2.d_rvalid, b2.if_rvalid, b2.d_rdata},
                              {2'b10, 32'hA5000020});
        end
    endtask

    initial begin
        b2.if_req = 1'b0; b2.if_addr = '0; b2.d_req = 1'b0; b2.d_we = 1'b0; b2.d_addr = '0; b2.d_wdata = '0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        b8.if_req = 1'b0; b8.if_addr = '0; b8.d_req = 1'b0; b8.d_we = 1'b0; b8.d_addr = '0; b8.d_wdata = '0;
        test_reset;
        test_fetch;
        test_store_load;
        test_priority;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
